// File: rtl/sc_pointplayer_pkg.sv
// Shared definitions for the player point datapath and its state machine.
// Holds the 2-bit shift-selection command encoding.
package sc_pointplayer_pkg;

    localparam logic [1:0] SHIFT_RSVD  = 2'b00;  // treated as hold
    localparam logic [1:0] SHIFT_LEFT  = 2'b01;  // toward MSB
    localparam logic [1:0] SHIFT_RIGHT = 2'b10;  // toward LSB
    localparam logic [1:0] SHIFT_HOLD  = 2'b11;

endpackage

// File: rtl/sc_pointedge_comparator.sv
// Side/edge comparator for the point register.
// Ports:
//   i_data           current point register
//   o_side_n         low when the register is all-zero (no point, moves disallowed)
//   o_left_edge_n    low when the MSB is set
//   o_right_edge_n   low when the LSB is set
// Pure combinational; depends only on the register, never on commands.
module sc_pointedge_comparator #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] i_data,
    output logic             o_side_n,
    output logic             o_left_edge_n,
    output logic             o_right_edge_n
);

    assign o_side_n       = |i_data;
    assign o_left_edge_n  = ~i_data[WIDTH-1];
    assign o_right_edge_n = ~i_data[0];

endmodule

// File: rtl/sc_pointregister_player.sv
// Player point register: one-hot point position moved left/right by the
// player state machine, with clear/load strobes, edge flags, a per-move pulse
// and a saturating move counter.
// Ports:
//   SC_POINTREGISTER_CLOCK_50            system clock
//   SC_POINTREGISTER_RESET_InHigh        synchronous active-high reset
//   SC_POINTREGISTER_clear_InLow         clear strobe (active low)
//   SC_POINTREGISTER_load_InLow          load INIT_VALUE strobe (active low)
//   SC_POINTREGISTER_shiftselection_In   01 left, 10 right, 11/00 hold
//   SC_POINTREGISTER_data_Out            point register
//   SC_POINTREGISTER_sidecomparator_OutLow  low when register is zero
//   SC_POINTREGISTER_leftEdge_OutLow     low when MSB set
//   SC_POINTREGISTER_rightEdge_OutLow    low when LSB set
//   SC_POINTREGISTER_moved_Out           pulse the cycle after an accepted move
//   SC_POINTREGISTER_moveCount_Out       accepted moves since clear/load (saturating)
module sc_pointregister_player
    import sc_pointplayer_pkg::*;
#(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] INIT_VALUE  = WIDTH'(8'b0001_0000),
    parameter int               WRAP        = 0,
    parameter int               COUNT_WIDTH = 8
) (
    input  logic                   SC_POINTREGISTER_CLOCK_50,
    input  logic                   SC_POINTREGISTER_RESET_InHigh,
    input  logic                   SC_POINTREGISTER_clear_InLow,
    input  logic                   SC_POINTREGISTER_load_InLow,
    input  logic [1:0]             SC_POINTREGISTER_shiftselection_In,
    output logic [WIDTH-1:0]       SC_POINTREGISTER_data_Out,
    output logic                   SC_POINTREGISTER_sidecomparator_OutLow,
    output logic                   SC_POINTREGISTER_leftEdge_OutLow,
    output logic                   SC_POINTREGISTER_rightEdge_OutLow,
    output logic                   SC_POINTREGISTER_moved_Out,
    output logic [COUNT_WIDTH-1:0] SC_POINTREGISTER_moveCount_Out
);

    localparam logic [WIDTH-1:0] LSB_ONE = WIDTH'(1);
    localparam logic [WIDTH-1:0] MSB_ONE = LSB_ONE << (WIDTH - 1);

    logic [WIDTH-1:0]       r_data;
    logic [COUNT_WIDTH-1:0] r_count;
    logic                   r_moved;

    logic [WIDTH-1:0]       w_next;
    logic                   w_accept;

    // Candidate move. An empty register never moves, so the register can only
    // ever hold zero or a single set bit.
    always_comb begin
        w_next   = r_data;
        w_accept = 1'b0;
        if (r_data != '0) begin
            case (SC_POINTREGISTER_shiftselection_In)
                SHIFT_LEFT: begin
                    if (!r_data[WIDTH-1]) begin
                        w_next   = r_data << 1;
                        w_accept = 1'b1;
                    end else if (WRAP != 0) begin
                        w_next   = LSB_ONE;
                        w_accept = 1'b1;
                    end
                end
                SHIFT_RIGHT: begin
                    if (!r_data[0]) begin
                        w_next   = r_data >> 1;
                        w_accept = 1'b1;
                    end else if (WRAP != 0) begin
                        w_next   = MSB_ONE;
                        w_accept = 1'b1;
                    end
                end
                default: ;  // hold / reserved
            endcase
        end
    end

    // Priority: reset > clear > load > shift > hold.
    always_ff @(posedge SC_POINTREGISTER_CLOCK_50) begin
        if (SC_POINTREGISTER_RESET_InHigh) begin
            r_data  <= '0;
            r_count <= '0;
            r_moved <= 1'b0;
        end else if (!SC_POINTREGISTER_clear_InLow) begin
            r_data  <= '0;
            r_count <= '0;
            r_moved <= 1'b0;
        end else if (!SC_POINTREGISTER_load_InLow) begin
            r_data  <= INIT_VALUE;
            r_count <= '0;
            r_moved <= 1'b0;
        end else begin
            r_moved <= w_accept;
            if (w_accept) begin
                r_data <= w_next;
                if (r_count != '1)
                    r_count <= r_count + COUNT_WIDTH'(1);
            end
        end
    end

    sc_pointedge_comparator #(
        .WIDTH (WIDTH)
    ) u_edge (
        .i_data         (r_data),
        .o_side_n       (SC_POINTREGISTER_sidecomparator_OutLow),
        .o_left_edge_n  (SC_POINTREGISTER_leftEdge_OutLow),
        .o_right_edge_n (SC_POINTREGISTER_rightEdge_OutLow)
    );

    assign SC_POINTREGISTER_data_Out      = r_data;
    assign SC_POINTREGISTER_moveCount_Out = r_count;
    assign SC_POINTREGISTER_moved_Out     = r_moved;

endmodule

// File: doc/sc_pointregister_player.md
# sc_pointregister_player

Player point datapath: the responder to the player point state machine's active-low clear/load strobes and 2-bit shift-selection command. It holds a one-hot point position, moves it left or right one bit per command, and returns the active-low side comparator that the state machine uses to gate LEFT/RIGHT moves. It also exports edge flags, a per-move pulse and a move counter for the display and scoring logic.

## Interface
- WIDTH, 8, point field width in bits
- INIT_VALUE, 8'b0001_0000, position written by load; must be one-hot within WIDTH
- WRAP, 0, 0 = saturate at field edges, 1 = wrap MSB<->LSB
- COUNT_WIDTH, 8, move counter width
- SC_POINTREGISTER_CLOCK_50  in  1  single system clock, all state on rising edge
- SC_POINTREGISTER_RESET_InHigh  in  1  reset, synchronous, active-high
- SC_POINTREGISTER_clear_InLow  in  1  clear strobe, active low
- SC_POINTREGISTER_load_InLow  in  1  load INIT_VALUE strobe, active low
- SC_POINTREGISTER_shiftselection_In  in  2  01 = shift left (toward MSB), 10 = shift right, 11 = hold, 00 = reserved/hold
- SC_POINTREGISTER_data_Out  out  WIDTH  current point register
- SC_POINTREGISTER_sidecomparator_OutLow  out  1  low when register is all-zero (no point; moves disallowed)
- SC_POINTREGISTER_leftEdge_OutLow  out  1  low when data_Out[WIDTH-1] = 1
- SC_POINTREGISTER_rightEdge_OutLow  out  1  low when data_Out[0] = 1
- SC_POINTREGISTER_moved_Out  out  1  one-cycle pulse after each accepted move
- SC_POINTREGISTER_moveCount_Out  out  COUNT_WIDTH  accepted moves since last clear/load, saturating

## Operation
- Reset (synchronous, one edge with RESET high): data = 0, moveCount = 0, moved = 0; hence sidecomparator = 0, leftEdge = 1, rightEdge = 1. Reset overrides every other input.
- Per rising edge, priority: reset > clear > load > shift > hold.
- Clear low: data = 0, moveCount = 0, moved = 0.
- Load low (clear high): data = INIT_VALUE, moveCount = 0, moved = 0.
- Shift command with data = 0: ignored, no pulse, no count.
- Left, bit WIDTH-1 clear: data <<= 1; accepted.
- Left, bit WIDTH-1 set: WRAP=0 -> unchanged, not accepted; WRAP=1 -> data = 1, accepted.
- Right, bit 0 clear: data >>= 1; accepted.
- Right, bit 0 set: WRAP=0 -> unchanged, not accepted; WRAP=1 -> data = 1<<(WIDTH-1), accepted.
- Accepted move: moved = 1 next cycle, moveCount += 1 unless already all-ones (saturates, no wrap).
- Codes 11 and 00: hold; moved = 0.
- Register is always zero or one-hot; no input sequence may produce multiple set bits.
- Edge/side flags are pure functions of the current register, not of inputs.

## Timing
- Commands sampled on the rising edge that ends the cycle in which they are driven; the state machine drives each strobe for exactly one cycle, giving exactly one action per strobe.
- A command held for N cycles produces N actions (N moves, subject to edge rules).
- data_Out, moveCount_Out, moved_Out registered; update one edge after command.
- sidecomparator/leftEdge/rightEdge combinational from data register; valid in the same cycle data_Out changes, before the next edge, so the state machine's CHECK state sees current values.
- moved_Out high exactly the cycle after an accepted move; back-to-back moves keep it high on consecutive cycles.
- Reset asserted mid-sequence: next edge returns to reset values regardless of pending commands.

## Structure
- Package sc_pointplayer_pkg: shift-selection codes SHIFT_LEFT = 2'b01, SHIFT_RIGHT = 2'b10, SHIFT_HOLD = 2'b11, SHIFT_RSVD = 2'b00; shared with the state machine.
- One sub-module: sc_pointedge_comparator (WIDTH parameter; register in; sidecomparator, leftEdge, rightEdge out).
- Top holds point register, move counter, moved pulse flop.

## Test plan
- Reset high one edge with all strobes active -> data 0, sidecomparator 0, edges 1, moveCount 0, moved 0.
- Load low one cycle -> data 8'b0001_0000, sidecomparator 1; then 3 left commands -> 8'b1000_0000, leftEdge 0, moveCount 3, moved high 3 cycles.
- WRAP=0 at 8'b1000_0000, left -> unchanged, moved 0, count unchanged; WRAP=1 -> 8'b0000_0001, count +1.
- Clear and load low same cycle -> data 0, count 0; right command afterwards -> ignored, moved 0.
- Saturation with COUNT_WIDTH=2, WRAP=1: 5 accepted moves -> moveCount 3, moved still pulses each move.
- Reset asserted during a left command at 8'b0100_0000 -> data 0 next edge, no pulse.
